alarm_scheduler: RTL and testbench

//  Central sequencer for the alarm path: owns the run/alarm enable `en` shared by

---
 rtl/alarm_scheduler.sv | 172 +++++++++++++++++
 tb/tb_alarm_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// Alarm-path sequencer: owns the run enable, gates the beeper and arbitrates
// alarm, snooze, song upload and play completion/timeout.
module alarm_scheduler #(
    parameter int unsigned CLK_HZ          = 12_000_000,
    parameter int unsigned PLAY_TIMEOUT_MS = 60_000,
    parameter int unsigned COOLDOWN_MS     = 500,
    parameter int unsigned SNOOZE_MS       = 300_000,
    parameter int unsigned MAX_SNOOZE      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_flag,
    input  logic       snooze_req,
    input  logic       rx_done,
    input  logic [9:0] data_length,
    input  logic       play_done,
    output logic       en,
    output logic       beep_en,
    output logic       song_valid,
    output logic       alarm_missed,
    output logic       timeout_err,
    output logic [1:0] state
);

    localparam int unsigned TickCycles = CLK_HZ / 1000;
    localparam int unsigned PreW       = (TickCycles > 1) ? $clog2(TickCycles) : 1;
    localparam int unsigned MsMax01    = (PLAY_TIMEOUT_MS > COOLDOWN_MS) ?
                                         PLAY_TIMEOUT_MS : COOLDOWN_MS;
    localparam int unsigned MsMax      = (MsMax01 > SNOOZE_MS) ? MsMax01 : SNOOZE_MS;
    localparam int unsigned MsW        = $clog2(MsMax + 1);
    localparam int unsigned SnzW       = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [PreW-1:0] PreLast    = PreW'(TickCycles - 1);
    localparam logic [MsW-1:0]  MsSat      = {MsW{1'b1}};
    localparam logic [MsW-1:0]  PlayLast   = MsW'(PLAY_TIMEOUT_MS - 1);
    localparam logic [MsW-1:0]  CoolLast   = MsW'(COOLDOWN_MS - 1);
    localparam logic [MsW-1:0]  SnoozeLast = MsW'(SNOOZE_MS - 1);
    localparam logic [SnzW-1:0] SnzLimit   = SnzW'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPlay   = 2'd1,
        StCool   = 2'd2,
        StSnooze = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [MsW-1:0]  ms_q, ms_d;
    logic [SnzW-1:0] snz_cnt_q, snz_cnt_d;
    logic            en_q, en_d;
    logic            beep_en_q, beep_en_d;
    logic            song_valid_q, song_valid_d;
    logic            alarm_missed_q, alarm_missed_d;
    logic            timeout_err_q, timeout_err_d;

    logic ms_tick;
    logic play_expired;
    logic cool_expired;
    logic snooze_expired;
    logic state_change;

    // The last cycle of an N ms interval is the tick that completes ms N-1.
    assign ms_tick        = (pre_q == PreLast);
    assign play_expired   = ms_tick && (ms_q == PlayLast);
    assign cool_expired   = ms_tick && (ms_q == CoolLast);
    assign snooze_expired = ms_tick && (ms_q == SnoozeLast);

    always_comb begin
        state_d        = state_q;
        snz_cnt_d      = snz_cnt_q;
        timeout_err_d  = timeout_err_q;
        alarm_missed_d = 1'b0;

        song_valid_d = song_valid_q;
        if (rx_done) begin
            song_valid_d = (data_length != 10'd0);
        end

        unique case (state_q)
            StIdle: begin
                if (alarm_flag) begin
                    if (song_valid_q) begin
                        state_d       = StPlay;
                        timeout_err_d = 1'b0;
                    end else begin
                        alarm_missed_d = 1'b1;
                    end
                end
            end
            StPlay: begin
                if (play_done) begin
                    state_d = StCool;
                end else if (snooze_req && (snz_cnt_q < SnzLimit)) begin
                    state_d   = StSnooze;
                    snz_cnt_d = snz_cnt_q + SnzW'(1);
                end else if (play_expired) begin
                    state_d       = StCool;
                    timeout_err_d = 1'b1;
                end
            end
            StCool: begin
                if (cool_expired) begin
                    state_d = StIdle;
                end
            end
            StSnooze: begin
                if (alarm_flag) begin
                    state_d = StPlay;
                end else if (snooze_expired) begin
                    if (song_valid_q) begin
                        state_d = StPlay;
                    end else begin
                        state_d        = StIdle;
                        alarm_missed_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        state_change = (state_d != state_q);

        // Snooze budget is per alarm event, so it refills on every return to IDLE.
        if (state_change && (state_d == StIdle)) begin
            snz_cnt_d = '0;
        end

        if (state_change) begin
            pre_d = '0;
            ms_d  = '0;
        end else begin
            pre_d = ms_tick ? '0 : pre_q + PreW'(1);
            ms_d  = (ms_tick && (ms_q != MsSat)) ? ms_q + MsW'(1) : ms_q;
        end

        en_d      = (state_d == StIdle) || (state_d == StSnooze);
        beep_en_d = (state_d == StPlay);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            pre_q          <= '0;
            ms_q           <= '0;
            snz_cnt_q      <= '0;
            en_q           <= 1'b1;
            beep_en_q      <= 1'b0;
            song_valid_q   <= 1'b0;
            alarm_missed_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_q          <= pre_d;
            ms_q           <= ms_d;
            snz_cnt_q      <= snz_cnt_d;
            en_q           <= en_d;
            beep_en_q      <= beep_en_d;
            song_valid_q   <= song_valid_d;
            alarm_missed_q <= alarm_missed_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign en           = en_q;
    assign beep_en      = beep_en_q;
    assign song_valid   = song_valid_q;
    assign alarm_missed = alarm_missed_q;
    assign timeout_err  = timeout_err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with 1 ms = 1 cycle timing.
module tb_alarm_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       alarm_flag;
    logic       snooze_req;
    logic       rx_done;
    logic [9:0] data_length;
    logic       play_done;
    logic       en;
    logic       beep_en;
    logic       song_valid;
    logic       alarm_missed;
    logic       timeout_err;
    logic [1:0] state;

    int total  = 0;
    int passed = 0;

    alarm_scheduler #(
        .CLK_HZ         (1000),
        .PLAY_TIMEOUT_MS(20),
        .COOLDOWN_MS    (4),
        .SNOOZE_MS      (10),
        .MAX_SNOOZE     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alarm_flag  (alarm_flag),
        .snooze_req  (snooze_req),
        .rx_done     (rx_done),
        .data_length (data_length),
        .play_done   (play_done),
        .en          (en),
        .beep_en     (beep_en),
        .song_valid  (song_valid),
        .alarm_missed(alarm_missed),
        .timeout_err (timeout_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_song(input logic [9:0] len);
        rx_done     = 1'b1;
        data_length = len;
        tick();
        rx_done     = 1'b0;
    endtask

    task automatic pulse_alarm();
        alarm_flag = 1'b1;
        tick();
        alarm_flag = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze_req = 1'b1;
        tick();
        snooze_req = 1'b0;
    endtask

    task automatic finish_play(input string name);
        play_done = 1'b1;
        tick();
        play_done = 1'b0;
        for (int n = 0; n < 50 && state != 2'd0; n++) tick();
        total++;
        if (state !== 2'd0) $display("FAIL %s_idle: state=%0d want 0", name, state);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; alarm_flag = 1'b0; snooze_req = 1'b0; rx_done = 1'b0;
        data_length = 10'd0; play_done = 1'b0;
        tick(); tick();
        total++; if (en !== 1'b1) $display("FAIL rst_en: got %b want 1", en); else passed++;
        total++; if (beep_en !== 1'b0) $display("FAIL rst_beep: got %b want 0", beep_en);
        else passed++;
        total++; if (song_valid !== 1'b0) $display("FAIL rst_sv: got %b want 0", song_valid);
        else passed++;
        total++; if (alarm_missed !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL rst_flags: missed=%b terr=%b want 0 0", alarm_missed, timeout_err);
        else passed++;
        total++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state);
        else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_play_done();
        int en_low, beep_hi;
        logic [1:0] st5, st9;
        load_song(10'd12);
        total++; if (song_valid !== 1'b1) $display("FAIL t1_sv: got %b want 1", song_valid);
        else passed++;
        pulse_alarm();
        total++; if (state !== 2'd1) $display("FAIL t1_play: state=%0d want 1", state);
        else passed++;
        en_low = 0; beep_hi = 0; st5 = 2'd0; st9 = 2'd0;
        for (int i = 0; i < 15; i++) begin
            if (en === 1'b0) en_low++;
            if (beep_en === 1'b1) beep_hi++;
            if (i == 5) st5 = state;
            if (i == 9) st9 = state;
            play_done = (i == 4);
            tick();
        end
        play_done = 1'b0;
        total++; if (st5 !== 2'd2) $display("FAIL t1_cool: state=%0d want 2", st5); else passed++;
        total++; if (st9 !== 2'd0) $display("FAIL t1_idle: state=%0d want 0", st9); else passed++;
        total++; if (beep_hi != 5) $display("FAIL t1_beep_cycles: got %0d want 5", beep_hi);
        else passed++;
        total++; if (en_low != 9) $display("FAIL t1_en_low_cycles: got %0d want 9", en_low);
        else passed++;
    endtask

    task automatic test_no_song();
        load_song(10'd0);
        total++; if (song_valid !== 1'b0) $display("FAIL t2_sv_clear: got %b want 0", song_valid);
        else passed++;
        alarm_flag = 1'b1;
        tick();
        alarm_flag = 1'b0;
        total++; if (alarm_missed !== 1'b1 || en !== 1'b1 || state !== 2'd0)
            $display("FAIL t2_missed: missed=%b en=%b state=%0d want 1 1 0",
                     alarm_missed, en, state);
        else passed++;
        tick();
        total++; if (alarm_missed !== 1'b0) $display("FAIL t2_pulse: got %b want 0", alarm_missed);
        else passed++;
        // Alarm and upload together: the pre-upload (empty) song state decides.
        alarm_flag = 1'b1; rx_done = 1'b1; data_length = 10'd5;
        tick();
        alarm_flag = 1'b0; rx_done = 1'b0;
        total++; if (state !== 2'd0 || alarm_missed !== 1'b1 || song_valid !== 1'b1)
            $display("FAIL t2_same_cycle: state=%0d missed=%b sv=%b want 0 1 1",
                     state, alarm_missed, song_valid);
        else passed++;
        tick();
    endtask

    task automatic test_timeout();
        int play_cycles;
        load_song(10'd7);
        pulse_alarm();
        play_cycles = 0;
        for (int i = 0; i < 25; i++) begin
            if (state === 2'd1) play_cycles++;
            tick();
        end
        total++; if (play_cycles != 20) $display("FAIL t3_play_len: got %0d want 20", play_cycles);
        else passed++;
        total++; if (timeout_err !== 1'b1 || state !== 2'd0)
            $display("FAIL t3_terr: terr=%b state=%0d want 1 0", timeout_err, state);
        else passed++;
        pulse_alarm();
        total++; if (timeout_err !== 1'b0 || state !== 2'd1)
            $display("FAIL t3_terr_clear: terr=%b state=%0d want 0 1", timeout_err, state);
        else passed++;
        finish_play("t3");
    endtask

    task automatic test_snooze_limit();
        int n;
        logic en_bad;
        pulse_alarm();
        for (int k = 0; k < 3; k++) begin
            pulse_snooze();
            total++; if (state !== 2'd3 || en !== 1'b1 || beep_en !== 1'b0)
                $display("FAIL t4_snooze%0d: state=%0d en=%b beep=%b want 3 1 0",
                         k, state, en, beep_en);
            else passed++;
            n = 0; en_bad = 1'b0;
            while (state === 2'd3 && n < 30) begin
                if (en !== 1'b1) en_bad = 1'b1;
                n++;
                tick();
            end
            total++; if (n != 10 || en_bad || state !== 2'd1)
                $display("FAIL t4_period%0d: cycles=%0d en_bad=%b state=%0d want 10 0 1",
                         k, n, en_bad, state);
            else passed++;
        end
        pulse_snooze();
        total++; if (state !== 2'd1 || beep_en !== 1'b1)
            $display("FAIL t4_limit: state=%0d beep=%b want 1 1", state, beep_en);
        else passed++;
        finish_play("t4");
    endtask

    task automatic test_priority();
        pulse_alarm();
        play_done = 1'b1; snooze_req = 1'b1;
        tick();
        play_done = 1'b0; snooze_req = 1'b0;
        total++; if (state !== 2'd2) $display("FAIL t5_done_wins: state=%0d want 2", state);
        else passed++;
        for (int n = 0; n < 50 && state != 2'd0; n++) tick();
        pulse_alarm();
        pulse_snooze();
        tick(); tick();
        pulse_alarm();
        total++; if (state !== 2'd1 || beep_en !== 1'b1 || en !== 1'b0)
            $display("FAIL t5_alarm_in_snooze: state=%0d beep=%b en=%b want 1 1 0",
                     state, beep_en, en);
        else passed++;
        finish_play("t5");
    endtask

    task automatic test_snooze_no_song();
        int n;
        pulse_alarm();
        load_song(10'd0);
        total++; if (state !== 2'd1 || song_valid !== 1'b0)
            $display("FAIL t7_no_abort: state=%0d sv=%b want 1 0", state, song_valid);
        else passed++;
        pulse_snooze();
        n = 0;
        while (state === 2'd3 && n < 30) begin
            n++;
            tick();
        end
        total++; if (state !== 2'd0 || alarm_missed !== 1'b1)
            $display("FAIL t7_snooze_missed: state=%0d missed=%b want 0 1", state, alarm_missed);
        else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        load_song(10'd3);
        pulse_alarm();
        total++; if (beep_en !== 1'b1) $display("FAIL t6_pre: beep=%b want 1", beep_en);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (en !== 1'b1 || beep_en !== 1'b0 || state !== 2'd0)
            $display("FAIL t6_async: en=%b beep=%b state=%0d want 1 0 0", en, beep_en, state);
        else passed++;
        tick();
        rst = 1'b0;
        tick();
        total++; if (song_valid !== 1'b0 || en !== 1'b1)
            $display("FAIL t6_after: sv=%b en=%b want 0 1", song_valid, en);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_play_done();
        test_no_song();
        test_timeout();
        test_snooze_limit();
        test_priority();
        test_snooze_no_song();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
